// File: rtl/shift_seq8.sv
// Command sequencer for the 8-bit registered shifter: one request becomes a LOAD,
// up to five shift commands of at most 3 bits, a capture of the shifter output and a done pulse.
module shift_seq8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic [1:0] dir,
  input  logic [3:0] amount,
  input  logic [7:0] sh_out,
  output logic [2:0] op,
  output logic [1:0] shamt,
  output logic [7:0] d_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  state_t     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] dir_q, dir_d;
  logic [7:0] d_in_q, d_in_d;
  logic [7:0] result_q, result_d;
  logic [1:0] chunk;

  // Largest shift the shifter accepts per command is 3 bits.
  assign chunk = (rem_q > 4'd3) ? 2'd3 : rem_q[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rem_q    <= 4'd0;
      dir_q    <= 2'b00;
      d_in_q   <= 8'h00;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      d_in_q   <= d_in_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    d_in_d   = d_in_q;
    result_d = result_q;
    op       = OP_NOP;
    shamt    = 2'd0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d   = dir;
          d_in_d  = data;
          rem_d   = (dir == 2'b11) ? 4'd0 : amount;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        op      = OP_LOAD;
        busy    = 1'b1;
        state_d = (rem_q == 4'd0) ? ST_CAPT : ST_SHIFT;
      end
      ST_SHIFT: begin
        busy  = 1'b1;
        shamt = chunk;
        case (dir_q)
          2'b00:   op = OP_LSL;
          2'b01:   op = OP_LSR;
          2'b10:   op = OP_ASR;
          default: op = OP_NOP;
        endcase
        rem_d = rem_q - {2'b00, chunk};
        if (rem_d == 4'd0) begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        busy     = 1'b1;
        result_d = sh_out;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign d_in   = d_in_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8 with a behavioural registered shifter attached;
// expected results are queued at request time and popped when done pulses.
module tb_shift_seq8;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] data;
  logic [1:0] dir;
  logic [3:0] amount;
  logic [7:0] sh_out;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_in;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];

  shift_seq8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .data    (data),
    .dir     (dir),
    .amount  (amount),
    .sh_out  (sh_out),
    .op      (op),
    .shamt   (shamt),
    .d_in    (d_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered shifter model driven by the sequencer.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_out <= 8'h00;
    end else begin
      case (op)
        3'b001:  sh_out <= d_in;
        3'b010:  sh_out <= sh_out << shamt;
        3'b011:  sh_out <= sh_out >> shamt;
        3'b100:  sh_out <= 8'($signed(sh_out) >>> shamt);
        default: sh_out <= sh_out;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [1:0] dr, input logic [3:0] amt);
    logic [23:0] wide;
    case (dr)
      2'b00: begin
        wide = {16'h0, d} << amt;
        return wide[7:0];
      end
      2'b01:   return d >> amt;
      2'b10:   return 8'($signed(d) >>> amt);
      default: return d;
    endcase
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 32'(done), 32'd0);
      end else begin
        check_eq("result", 32'(result), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_op"},     32'(op),     32'd0);
    check_eq({tag, "_shamt"},  32'(shamt),  32'd0);
    check_eq({tag, "_d_in"},   32'(d_in),   32'd0);
    check_eq({tag, "_busy"},   32'(busy),   32'd0);
    check_eq({tag, "_done"},   32'(done),   32'd0);
    check_eq({tag, "_result"}, 32'(result), 32'd0);
  endtask

  // One request; checks op/shamt/busy/done in every cycle up to the done cycle.
  // abort_cyc > 0 asserts reset in that cycle; inject_cyc > 0 pulses a stray start there.
  task automatic run_op(input logic [7:0] d, input logic [1:0] dr, input logic [3:0] amt,
                        input int abort_cyc, input int inject_cyc);
    int rem0, k, r, ch;
    logic [2:0] exp_op, sop;
    logic [1:0] exp_sh;
    logic [7:0] exp_res;
    rem0 = (dr == 2'b11) ? 0 : int'(amt);
    k    = (rem0 + 2) / 3;
    r    = rem0;
    sop  = (dr == 2'b00) ? 3'b010 : (dr == 2'b01) ? 3'b011 : 3'b100;
    exp_res = ref_shift(d, dr, amt);
    sb_q.push_back(exp_res);
    $display("req data=0x%02h dir=%0d amount=%0d chunks=%0d expect result=0x%02h done in cycle %0d",
             d, dr, amt, k, exp_res, k + 3);
    @(negedge clk);
    start = 1'b1; data = d; dir = dr; amount = amt;
    @(posedge clk);
    #1;
    start = 1'b0; data = 8'hA5; dir = 2'b00; amount = 4'hF;
    for (int c = 1; c <= k + 3; c++) begin
      @(negedge clk);
      exp_sh = 2'd0;
      if (c == 1) begin
        exp_op = 3'b001;
      end else if (c <= k + 1) begin
        ch     = (r > 3) ? 3 : r;
        r      = r - ch;
        exp_op = sop;
        exp_sh = 2'(ch);
      end else begin
        exp_op = 3'b000;
      end
      check_eq($sformatf("op_c%0d", c),    32'(op),    32'(exp_op));
      check_eq($sformatf("shamt_c%0d", c), 32'(shamt), 32'(exp_sh));
      check_eq($sformatf("busy_c%0d", c),  32'(busy),  32'(c <= k + 2));
      check_eq($sformatf("done_c%0d", c),  32'(done),  32'(c == k + 3));
      if (c == 1) check_eq("d_in_load", 32'(d_in), 32'(d));
      if (c == abort_cyc) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        void'(sb_q.pop_back());
        repeat (2) begin
          @(negedge clk);
          check_eq("abort_no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        return;
      end
      if (c == inject_cyc) begin
        start = 1'b1; data = 8'h12; dir = 2'b00; amount = 4'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; data = 8'h00; dir = 2'b00; amount = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_op(8'h77, 2'b00, 4'd1,  0, 0);
    run_op(8'h88, 2'b10, 4'd7,  0, 0);
    run_op(8'h35, 2'b00, 4'd9,  2, 0);
    run_op(8'h01, 2'b00, 4'd2,  0, 0);
    run_op(8'h77, 2'b01, 4'd0,  0, 0);
    run_op(8'h77, 2'b11, 4'd9,  0, 0);
    run_op(8'hF0, 2'b01, 4'd15, 0, 3);
    repeat (4) begin
      @(negedge clk);
      check_eq("ignored_start_done", 32'(done),   32'd0);
      check_eq("ignored_start_res",  32'(result), 32'h00);
    end
    run_op(8'h81, 2'b10, 4'd8,  0, 0);
    for (int i = 0; i < 8; i++) begin
      run_op(8'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0, 0);
    end

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq8.md
# shift_seq8

Command sequencer that drives the 8-bit registered shifter (op/shamt/d_in → d_out interface) as its initiator. It accepts a one-cycle request carrying an 8-bit operand, a shift kind and a total shift distance of 0–15. It then issues the LOAD and as many shift commands of at most 3 bits as the distance needs, captures the shifter output, and signals completion. It sits between control logic and one shifter instance, so callers never sequence shifter opcodes themselves.

## Interface
Parameters: none (widths fixed: data 8, op 3, shamt 2, distance 4).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request strobe; sampled only in IDLE
- data  input  8  operand, latched when start is accepted
- dir  input  2  00 LSL, 01 LSR, 10 ASR, 11 pass-through (no shift)
- amount  input  4  total shift distance 0–15, latched with data
- sh_out  input  8  shifter d_out (registered in the shifter)
- op  output  3  shifter opcode: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR
- shamt  output  2  shifter shift amount for the current shift command
- d_in  output  8  shifter load data
- busy  output  1  high from LOAD through CAPT
- done  output  1  one-cycle completion pulse
- result  output  8  captured final value; holds until the next capture

## Operation
- States: IDLE, LOAD, SHIFT, CAPT, DONE.
- IDLE: op=000, busy=0.
  - start=1 latches data, dir and amount (rem ← amount, or 0 if dir=11) → LOAD.
  - start=0 → stay in IDLE.
- LOAD (1 cycle): op=001, d_in=latched data, busy=1.
  - rem=0 → CAPT, otherwise → SHIFT.
- SHIFT (1 cycle per chunk): op = 010/011/100 per dir; shamt = min(rem,3); rem ← rem − shamt.
  - New rem=0 → CAPT, otherwise stay in SHIFT.
  - shamt is never 0 in SHIFT.
  - Chunk count k = ceil(rem0/3), where rem0 is the latched distance: 0..5 cycles.
- CAPT (1 cycle): op=000, busy=1; result ← sh_out at the end of the cycle → DONE.
- DONE (1 cycle): done=1, busy=0, op=000 → IDLE.
- Outside LOAD, d_in holds its last driven value; outside SHIFT, shamt = 0.
- start is ignored in every state except IDLE, including DONE. No queuing.
- Distances ≥ 8 are issued in full. The shifter produces 0x00 for LSL/LSR and sign fill for ASR; the sequencer does not saturate them.
- The sequencer does not check sh_out except when it captures it in CAPT.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, rem=0
  - op=000, shamt=00, d_in=0x00
  - busy=0, done=0, result=0x00
- Outputs (op, shamt, d_in, busy, done) are registered or pure state decodes, with no combinational path from start.
- Let edge 0 be the edge that samples start=1. Then:
  - LOAD occupies cycle 1.
  - SHIFT occupies cycles 2..k+1.
  - CAPT occupies cycle k+2.
  - done is high during cycle k+3.
  - The next start is accepted at the end of cycle k+4 at the earliest.
- The shifter updates d_out at the edge ending each op cycle, so sh_out is final throughout CAPT.
- Reset mid-operation aborts immediately. No done pulse is produced, result returns to 0x00, and the shifter must be reloaded.

## Test plan
- LSL, data 0x77, amount 1: op sequence 001, 010(shamt 1), 000. result=0xEE with done high 4 cycles after the start edge.
- ASR, data 0x88, amount 7: shamt sequence 3,3,1 over 3 SHIFT cycles. result=0xFF with done in cycle 6.
- LSR, data 0x77, amount 0, and a second run with dir=11, amount 9: no SHIFT cycles in either run. result=0x77 with done in cycle 3 for both.
- LSR, data 0xF0, amount 15: 5 SHIFT cycles, each shamt=3. result=0x00 with done in cycle 8. A start pulse with data 0x12 during busy must be ignored, leaving result=0x00 and no extra done.
- Reset asserted during SHIFT: all outputs return to reset values immediately, and done stays 0. After release, a new LSL, data 0x01, amount 2 request gives result 0x04.
